sync_pulse_train_gen: RTL and testbench

Synthesizable, parametrised multi-channel pulse-train generator for the synchronization block.
- Each channel produces a programmable train: start delay, pulse width, period, repeat count.
- The train is launched either by a common arm strobe (free burst, e.g. frame-grabber opto train) or by a per-channel trigger edge (delayed response, e.g. shutter-open after opto, detector-busy after output trigger).
- Used as a stimulus source on the bench and as the programmable timing engine in the FPGA.

---
 rtl/sync_pulse_train_gen.sv | 180 ++++++++++++++++++
 tb/tb_sync_pulse_train_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_train_gen.sv
// Multi-channel programmable pulse-train generator.
// Each channel launches on the shared arm strobe or its own trigger edge, and produces delay/width/period/repeat timing.
module sync_pulse_train_gen #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int REP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [N_CH-1:0]         trig_in,
    input  logic [N_CH-1:0]         cfg_mode,
    input  logic [N_CH*CNT_W-1:0]   cfg_delay,
    input  logic [N_CH*CNT_W-1:0]   cfg_width,
    input  logic [N_CH*CNT_W-1:0]   cfg_period,
    input  logic [N_CH*REP_W-1:0]   cfg_repeat,
    output logic [N_CH-1:0]         pulse_out,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         cfg_err,
    output logic [N_CH-1:0]         trig_missed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_LOW
    } state_t;

    logic [N_CH-1:0] trig_prev;
    logic [N_CH-1:0] trig_rise;

    // Tracks trig_in even during reset, so a level held through reset is never seen as an edge.
    always_ff @(posedge clk) begin
        trig_prev <= trig_in;
    end

    assign trig_rise = trig_in & ~trig_prev;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t            state, state_nx;
        logic [CNT_W-1:0]  cnt, cnt_nx;
        logic [CNT_W-1:0]  sh_width, sh_width_nx;
        logic [CNT_W-1:0]  sh_gap, sh_gap_nx;
        logic [REP_W-1:0]  rep_left, rep_left_nx;
        logic              sh_cont, sh_cont_nx;
        logic              sh_mode, sh_mode_nx;
        logic              pulse_r, busy_r;
        logic              done_r, done_nx;
        logic              err_r, err_nx;
        logic              miss_r, miss_nx;
        logic [CNT_W-1:0]  c_delay, c_width, c_period;
        logic [REP_W-1:0]  c_repeat;
        logic              launch, cfg_bad;

        assign c_delay  = cfg_delay[c*CNT_W +: CNT_W];
        assign c_width  = cfg_width[c*CNT_W +: CNT_W];
        assign c_period = cfg_period[c*CNT_W +: CNT_W];
        assign c_repeat = cfg_repeat[c*REP_W +: REP_W];
        assign launch   = cfg_mode[c] ? trig_rise[c] : arm;
        assign cfg_bad  = (c_width == '0) ||
                          ((c_repeat != REP_W'(1)) && (c_period <= c_width));

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= S_IDLE;
                cnt      <= '0;
                sh_width <= '0;
                sh_gap   <= '0;
                rep_left <= '0;
                sh_cont  <= 1'b0;
                sh_mode  <= 1'b0;
                pulse_r  <= 1'b0;
                busy_r   <= 1'b0;
                done_r   <= 1'b0;
                err_r    <= 1'b0;
                miss_r   <= 1'b0;
            end else begin
                state    <= state_nx;
                cnt      <= cnt_nx;
                sh_width <= sh_width_nx;
                sh_gap   <= sh_gap_nx;
                rep_left <= rep_left_nx;
                sh_cont  <= sh_cont_nx;
                sh_mode  <= sh_mode_nx;
                pulse_r  <= (state_nx == S_HIGH);
                busy_r   <= (state_nx != S_IDLE);
                done_r   <= done_nx;
                err_r    <= err_nx;
                miss_r   <= miss_nx;
            end
        end

        always_comb begin
            state_nx    = state;
            cnt_nx      = cnt;
            sh_width_nx = sh_width;
            sh_gap_nx   = sh_gap;
            rep_left_nx = rep_left;
            sh_cont_nx  = sh_cont;
            sh_mode_nx  = sh_mode;
            done_nx     = 1'b0;
            err_nx      = 1'b0;
            miss_nx     = 1'b0;

            if (abort) begin
                state_nx = S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (launch) begin
                            if (cfg_bad) begin
                                err_nx = 1'b1;
                            end else begin
                                sh_width_nx = c_width;
                                sh_gap_nx   = c_period - c_width;
                                rep_left_nx = c_repeat;
                                sh_cont_nx  = (c_repeat == '0);
                                sh_mode_nx  = cfg_mode[c];
                                if (c_delay == '0) begin
                                    state_nx = S_HIGH;
                                    cnt_nx   = c_width;
                                end else begin
                                    state_nx = S_DELAY;
                                    cnt_nx   = c_delay;
                                end
                            end
                        end
                    end
                    S_DELAY: begin
                        if (cnt == CNT_W'(1)) begin
                            state_nx = S_HIGH;
                            cnt_nx   = sh_width;
                        end else begin
                            cnt_nx = cnt - CNT_W'(1);
                        end
                    end
                    S_HIGH: begin
                        if (cnt == CNT_W'(1)) begin
                            // Validation guarantees a non-zero gap whenever another pulse follows.
                            if (!sh_cont && rep_left == REP_W'(1)) begin
                                state_nx = S_IDLE;
                                done_nx  = 1'b1;
                            end else begin
                                state_nx = S_LOW;
                                cnt_nx   = sh_gap;
                                if (!sh_cont) begin
                                    rep_left_nx = rep_left - REP_W'(1);
                                end
                            end
                        end else begin
                            cnt_nx = cnt - CNT_W'(1);
                        end
                    end
                    S_LOW: begin
                        if (cnt == CNT_W'(1)) begin
                            state_nx = S_HIGH;
                            cnt_nx   = sh_width;
                        end else begin
                            cnt_nx = cnt - CNT_W'(1);
                        end
                    end
                endcase

                if ((state != S_IDLE) && sh_mode && trig_rise[c]) begin
                    miss_nx = 1'b1;
                end
            end
        end

        assign pulse_out[c]   = pulse_r;
        assign busy[c]        = busy_r;
        assign done[c]        = done_r;
        assign cfg_err[c]     = err_r;
        assign trig_missed[c] = miss_r;
    end

endmodule

// File: tb/tb_sync_pulse_train_gen.sv
// Scoreboard bench for sync_pulse_train_gen: an arithmetic train model queues the expected outputs per cycle,
// and a monitor compares them against the DUT one time unit after each rising edge.
module tb_sync_pulse_train_gen;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int RW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int RMAX = (1 << RW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, arm, abort;
    logic [N-1:0]    trig_in, cfg_mode;
    logic [N*CW-1:0] cfg_delay, cfg_width, cfg_period;
    logic [N*RW-1:0] cfg_repeat;
    logic [N-1:0]    pulse_out, busy, done, cfg_err, trig_missed;

    sync_pulse_train_gen #(.N_CH(N), .CNT_W(CW), .REP_W(RW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_in(trig_in),
        .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_period(cfg_period), .cfg_repeat(cfg_repeat),
        .pulse_out(pulse_out), .busy(busy), .done(done), .cfg_err(cfg_err),
        .trig_missed(trig_missed)
    );

    typedef struct packed {
        logic [N-1:0] pulse;
        logic [N-1:0] busy;
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic [N-1:0] miss;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a train accepted in cycle t is described by its numbers alone.
    bit        m_run[N];
    bit        m_mode[N];
    int        m_t[N], m_d[N], m_w[N], m_p[N], m_r[N];
    logic [N-1:0] m_prev = '0;
    int        cyc = 0;

    function automatic int end_cycle(int c);
        return m_t[c] + 1 + m_d[c] + (m_r[c] - 1) * m_p[c] + m_w[c];
    endfunction

    task automatic tick();
        obs_t e;
        logic [N-1:0] rise;
        e    = '0;
        rise = trig_in & ~m_prev;
        m_prev = trig_in;
        for (int c = 0; c < N; c++) begin
            if (reset || abort) begin
                m_run[c] = 1'b0;
            end else begin
                bit free_ch, launch;
                int d, w, p, r;
                free_ch = !m_run[c] || (m_r[c] != 0 && cyc >= end_cycle(c));
                if (free_ch) begin
                    m_run[c] = 1'b0;
                    launch = cfg_mode[c] ? rise[c] : arm;
                    if (launch) begin
                        d = int'(cfg_delay[c*CW +: CW]);
                        w = int'(cfg_width[c*CW +: CW]);
                        p = int'(cfg_period[c*CW +: CW]);
                        r = int'(cfg_repeat[c*RW +: RW]);
                        if (w == 0 || (r != 1 && p <= w)) begin
                            e.err[c] = 1'b1;
                        end else begin
                            m_run[c] = 1'b1; m_mode[c] = cfg_mode[c]; m_t[c] = cyc;
                            m_d[c] = d; m_w[c] = w; m_p[c] = p; m_r[c] = r;
                        end
                    end
                end else if (m_mode[c] && rise[c]) begin
                    e.miss[c] = 1'b1;
                end
                if (m_run[c]) begin
                    int o, rel;
                    o = cyc + 1;
                    if (m_r[c] != 0 && o == end_cycle(c)) begin
                        e.done[c] = 1'b1;
                    end else begin
                        e.busy[c] = 1'b1;
                        rel = o - (m_t[c] + 1 + m_d[c]);
                        if (rel >= 0)
                            e.pulse[c] = (m_r[c] == 1) ? (rel < m_w[c]) : ((rel % m_p[c]) < m_w[c]);
                    end
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_ch(int c, bit mode, int d, int w, int p, int r);
        cfg_mode[c]             = mode;
        cfg_delay[c*CW +: CW]   = CW'(d);
        cfg_width[c*CW +: CW]   = CW'(w);
        cfg_period[c*CW +: CW]  = CW'(p);
        cfg_repeat[c*RW +: RW]  = RW'(r);
    endtask

    function automatic int pick_cnt();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return CMAX;
            2:       return 1;
            default: return int'($urandom_range(1, 6));
        endcase
    endfunction

    always @(posedge clk) begin : monitor
        obs_t a, e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {pulse_out, busy, done, cfg_err, trig_missed};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cyc%0d outputs: got pulse=%h busy=%h done=%h err=%h miss=%h, expected pulse=%h busy=%h done=%h err=%h miss=%h",
                         cyc, a.pulse, a.busy, a.done, a.err, a.miss,
                         e.pulse, e.busy, e.done, e.err, e.miss);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = '0;
        cfg_mode = '0; cfg_delay = '0; cfg_width = '0; cfg_period = '0; cfg_repeat = '0;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Free burst on arm
        set_ch(0, 0, 3, 2, 5, 3);
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (18) tick();

        // Triggered single pulse, level held high, then a fresh edge
        set_ch(1, 1, 0, 4, 9, 1);
        trig_in[1] = 1'b1; repeat (6) tick();
        trig_in[1] = 1'b0; tick();
        trig_in[1] = 1'b1; tick();
        trig_in[1] = 1'b0; repeat (6) tick();

        // Trigger while busy is reported and ignored
        set_ch(1, 1, 10, 2, 9, 1);
        trig_in[1] = 1'b1; tick();
        trig_in[1] = 1'b0; repeat (2) tick();
        trig_in[1] = 1'b1; tick();
        trig_in[1] = 1'b0; repeat (12) tick();

        // Rejected configurations
        set_ch(2, 0, 1, 5, 5, 2);
        arm = 1'b1; tick(); arm = 1'b0; repeat (3) tick();
        set_ch(2, 0, 0, 0, 4, 1);
        arm = 1'b1; tick(); arm = 1'b0; repeat (3) tick();

        // Continuous train stopped by abort
        set_ch(3, 0, 0, 1, 3, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (30) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        repeat (3) tick();

        // Reset mid-train with triggers held high
        for (int c = 0; c < N; c++) set_ch(c, 1, 1, 2, 4, 0);
        trig_in = '1; repeat (6) tick();
        reset = 1'b1; repeat (2) tick();
        reset = 1'b0; repeat (4) tick();
        trig_in = '0; tick();
        trig_in = '1; repeat (6) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        trig_in = '0;

        // Counter and repeat extremes
        set_ch(0, 0, CMAX, CMAX, 0, 1);
        set_ch(1, 0, 0, 3, CMAX, RMAX);
        set_ch(2, 1, 0, 1, 2, RMAX);
        set_ch(3, 1, CMAX, 1, 2, 1);
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (230) tick();

        // Randomized traffic, including config churn while trains run
        repeat (4000) begin
            reset = ($urandom_range(0, 999) == 0);
            abort = ($urandom_range(0, 299) == 0);
            arm   = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) trig_in[c] = ~trig_in[c];
            if ($urandom_range(0, 19) == 0) begin
                int c, w, p, r;
                c = int'($urandom_range(0, N - 1));
                w = pick_cnt();
                case ($urandom_range(0, 3))
                    0:       r = 0;
                    1:       r = 1;
                    2:       r = RMAX;
                    default: r = int'($urandom_range(0, RMAX));
                endcase
                if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, CMAX));
                else p = (w + int'($urandom_range(1, 4)) > CMAX) ? CMAX : w + int'($urandom_range(1, 4));
                set_ch(c, 1'($urandom_range(0, 1)), pick_cnt(), w, p, r);
            end
            tick();
        end

        reset = 1'b0; arm = 1'b0; abort = 1'b1; tick();
        abort = 1'b0; repeat (3) tick();
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
